// File: rtl/imem_port_arbiter_if.sv
// Requester-side bundle for the instruction memory port: one request
// handshake carrying a byte address, one response handshake carrying the
// instruction word and an error flag.
interface imem_port_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    // Requester view: issues requests, consumes responses
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Arbiter view: accepts requests, produces responses
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Two-requester (fetch, debug) arbiter in front of a combinational-read
// instruction memory. One transaction at a time: accept in IDLE, drive the
// memory for one cycle in ACCESS, hold the response in RESP until taken.
// Ties are broken round-robin against the last granted requester.
module imem_port_arbiter #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    imem_port_arbiter_if.slave f,
    imem_port_arbiter_if.slave d,
    output logic [31:0]        mem_addr,
    input  logic [31:0]        mem_rdata,
    output logic               busy
);

    // Highest byte address at which a whole word still fits in memory
    localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {REQ_F, REQ_D} req_t;

    state_t      state;
    state_t      state_nx;
    req_t        owner;
    req_t        last_grant;
    req_t        grant;
    logic        grant_f;
    logic        grant_d;
    logic        accept;
    logic        addr_ok;
    logic [31:0] addr_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant_f = f.req_valid && (!d.req_valid || last_grant == REQ_D);
        grant_d = d.req_valid && (!f.req_valid || last_grant == REQ_F);
        grant   = grant_d ? REQ_D : REQ_F;
        addr_ok = (addr_q[1:0] == 2'b00) && (addr_q <= ADDR_MAX);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and all handshake/memory outputs, decoded from the current state
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        busy        = 1'b1;
        mem_addr    = '0;
        f.req_ready = 1'b0;
        d.req_ready = 1'b0;
        f.rsp_valid = 1'b0;
        f.rsp_data  = '0;
        f.rsp_err   = 1'b0;
        d.rsp_valid = 1'b0;
        d.rsp_data  = '0;
        d.rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                busy        = 1'b0;
                f.req_ready = grant_f;
                d.req_ready = grant_d;
                if (grant_f || grant_d) begin
                    accept   = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (addr_ok) begin
                    mem_addr = addr_q;
                end
                state_nx = RESP;
            end
            RESP: begin
                if (owner == REQ_F) begin
                    f.rsp_valid = 1'b1;
                    f.rsp_data  = rsp_data_q;
                    f.rsp_err   = rsp_err_q;
                    if (f.rsp_ready) begin
                        state_nx = IDLE;
                    end
                end else begin
                    d.rsp_valid = 1'b1;
                    d.rsp_data  = rsp_data_q;
                    d.rsp_err   = rsp_err_q;
                    if (d.rsp_ready) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture on accept, response capture at the end of ACCESS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            owner      <= REQ_F;
            last_grant <= REQ_D;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            addr_q     <= (grant == REQ_D) ? d.req_addr : f.req_addr;
            owner      <= grant;
            last_grant <= grant;
        end else if (state == ACCESS) begin
            rsp_data_q <= addr_ok ? mem_rdata : '0;
            rsp_err_q  <= !addr_ok;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus a
// randomized run, all checked against a behavioural model of arbitration,
// address validity and memory contents kept in this file.
module tb_imem_port_arbiter;
    localparam int unsigned MEM_BYTES = 128;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_last;   // last granted requester in the model: 0 = fetch, 1 = debug

    typedef struct {
        int          who;
        int          lat;
        int          acc;
        logic [31:0] data;
        logic        err;
        logic [31:0] maddr;
        logic        other;
        logic        timeout;
    } obs_t;

    imem_port_arbiter_if fi();
    imem_port_arbiter_if di();

    imem_port_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .f         (fi),
        .d         (di),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational-read memory model
    assign mem_rdata = mem[mem_addr[6:2]];

    function automatic logic addr_valid(input logic [31:0] a);
        return (a % 4 == 0) && ({32'h0, a} + 64'd4 <= 64'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return addr_valid(a) ? mem[int'(a / 4)] : 32'h0;
    endfunction

    function automatic int exp_winner(input logic fv, input logic dv, input int last);
        if (fv && dv) return (last == 1) ? 0 : 1;
        return fv ? 0 : 1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 31)) * 4;
            1:       return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
            2:       return 32'($urandom_range(32, 1000)) * 4;
            default: return 32'($urandom);
        endcase
    endfunction

    // Reset pulse; returns just after a rising edge with the DUT idle
    task automatic do_reset();
        reset_n = 1'b0;
        fi.req_valid = 1'b0; di.req_valid = 1'b0;
        fi.rsp_ready = 1'b1; di.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        exp_last = 1;
    endtask

    // Drive one request set from IDLE (call just after a rising edge) and observe it
    task automatic run_txn(input logic fv, input logic [31:0] fa, input logic dv,
                           input logic [31:0] da, output obs_t o);
        int wcyc;
        o.who = -1; o.lat = -1; o.acc = -1; o.data = '0; o.err = 1'b0;
        o.maddr = '0; o.other = 1'b0; o.timeout = 1'b0;
        fi.req_valid = fv; fi.req_addr = fa; di.req_valid = dv; di.req_addr = da;
        fi.rsp_ready = 1'b1; di.rsp_ready = 1'b1;
        wcyc = 0;
        while (o.who < 0 && wcyc < 20) begin
            @(negedge clk);
            if (fi.req_valid && fi.req_ready) o.who = 0;
            else if (di.req_valid && di.req_ready) o.who = 1;
            wcyc++;
        end
        if (o.who < 0) begin
            o.timeout = 1'b1;
            return;
        end
        o.acc = cyc + 1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) o.maddr = mem_addr;
            if ((o.who == 0) ? di.rsp_valid : fi.rsp_valid) o.other = 1'b1;
            if ((o.who == 0) ? fi.rsp_valid : di.rsp_valid) begin
                o.lat  = k;
                o.data = (o.who == 0) ? fi.rsp_data : di.rsp_data;
                o.err  = (o.who == 0) ? fi.rsp_err : di.rsp_err;
                break;
            end
        end
        if (o.lat < 0) begin
            o.timeout = 1'b1;
            return;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fi.req_valid = 1'b1; fi.req_addr = 32'h0; di.req_valid = 1'b1; di.req_addr = 32'h4;
        fi.rsp_ready = 1'b1; di.rsp_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (fi.rsp_valid !== 1'b0 || di.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got f=%b d=%b expected 0 0", fi.rsp_valid, di.rsp_valid); end
        checks++; if (fi.rsp_data !== 32'h0 || fi.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", fi.rsp_data, fi.rsp_err); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b expected 0", busy); end
        @(negedge clk) reset_n = 1'b1;
        fi.req_valid = 1'b0; di.req_valid = 1'b0;
        @(posedge clk); #1;
        exp_last = 1;
    endtask

    task automatic test_single_fetch();
        obs_t o;
        do_reset();
        run_txn(1'b1, 32'h0, 1'b0, 32'h0, o);
        fi.req_valid = 1'b0;
        exp_last = 0;
        checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", o.timeout); end
        checks++; if (o.who !== 0) begin errors++; $display("FAIL single_who: got %0d expected 0", o.who); end
        checks++; if (o.lat !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", o.lat); end
        checks++; if (o.data !== 32'h00500113 || o.err !== 1'b0) begin errors++; $display("FAIL single_data: got %h/%b expected 00500113/0", o.data, o.err); end
        checks++; if (o.other !== 1'b0) begin errors++; $display("FAIL single_other_valid: got %b expected 0", o.other); end
    endtask

    task automatic test_tie();
        obs_t o;
        int   exp;
        do_reset();
        run_txn(1'b1, 32'h8, 1'b1, 32'h4, o);
        exp = exp_winner(1'b1, 1'b1, exp_last); exp_last = exp;
        checks++; if (o.who !== exp) begin errors++; $display("FAIL tie_first_who: got %0d expected %0d", o.who, exp); end
        checks++; if (o.data !== 32'hFF718393) begin errors++; $display("FAIL tie_first_data: got %h expected ff718393", o.data); end
        run_txn(1'b0, 32'h8, 1'b1, 32'h4, o);
        exp = exp_winner(1'b0, 1'b1, exp_last); exp_last = exp;
        checks++; if (o.who !== exp) begin errors++; $display("FAIL tie_second_who: got %0d expected %0d", o.who, exp); end
        checks++; if (o.data !== 32'h00C00193) begin errors++; $display("FAIL tie_second_data: got %h expected 00c00193", o.data); end
        run_txn(1'b1, 32'h8, 1'b1, 32'h4, o);
        exp = exp_winner(1'b1, 1'b1, exp_last); exp_last = exp;
        checks++; if (o.who !== exp) begin errors++; $display("FAIL tie_third_who: got %0d expected %0d", o.who, exp); end
        fi.req_valid = 1'b0; di.req_valid = 1'b0;
    endtask

    task automatic test_addr_errors();
        obs_t        o;
        logic [31:0] addrs [6];
        logic [31:0] a;
        logic        ok;
        addrs = '{32'h6, 32'h80, 32'h7C, 32'hFFFF_FFFC, 32'h7D, 32'h0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a  = addrs[i];
            ok = addr_valid(a);
            run_txn(1'b0, 32'h0, 1'b1, a, o);
            checks++; if (o.who !== 1 || o.lat !== 2) begin errors++; $display("FAIL err_txn[%h]: got who=%0d lat=%0d expected 1 2", a, o.who, o.lat); end
            checks++; if (o.err !== !ok || o.data !== exp_word(a)) begin errors++; $display("FAIL err_rsp[%h]: got %h/%b expected %h/%b", a, o.data, o.err, exp_word(a), !ok); end
            checks++; if (o.maddr !== (ok ? a : 32'h0)) begin errors++; $display("FAIL err_mem_addr[%h]: got %h expected %h", a, o.maddr, ok ? a : 32'h0); end
        end
        di.req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        obs_t o;
        do_reset();
        fi.req_valid = 1'b1; fi.req_addr = 32'h8; fi.rsp_ready = 1'b0;
        di.req_valid = 1'b0; di.rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (fi.req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b expected 1", fi.req_ready); end
        @(posedge clk); #1;
        fi.req_valid = 1'b0; di.req_valid = 1'b1; di.req_addr = 32'h4;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL bp_mem_addr: got %h expected 00000008", mem_addr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            di.rsp_ready = 1'($urandom_range(0, 1));
            checks++; if (fi.rsp_valid !== 1'b1 || fi.rsp_data !== 32'hFF718393 || fi.rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got %b %h %b expected 1 ff718393 0", i, fi.rsp_valid, fi.rsp_data, fi.rsp_err); end
            checks++; if (di.req_ready !== 1'b0 || busy !== 1'b1 || di.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_block[%0d]: got dready=%b busy=%b dvalid=%b expected 0 1 0", i, di.req_ready, busy, di.rsp_valid); end
        end
        fi.rsp_ready = 1'b1;
        @(posedge clk); #1;
        fi.rsp_ready = 1'b0; di.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (fi.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", fi.rsp_valid, busy); end
        checks++; if (di.req_ready !== 1'b1) begin errors++; $display("FAIL bp_next_grant: got %b expected 1", di.req_ready); end
        di.req_valid = 1'b0;
        @(posedge clk); #1;
        exp_last = 0;
        run_txn(1'b0, 32'h0, 1'b1, 32'h4, o);
        di.req_valid = 1'b0;
        exp_last = 1;
        checks++; if (o.who !== 1 || o.lat !== 2 || o.data !== 32'h00C00193) begin errors++; $display("FAIL bp_debug_txn: got who=%0d lat=%0d %h expected 1 2 00c00193", o.who, o.lat, o.data); end
    endtask

    task automatic test_drop();
        obs_t o;
        int   exp;
        do_reset();
        fi.req_valid = 1'b1; fi.req_addr = 32'h0; di.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (fi.req_ready !== 1'b1) begin errors++; $display("FAIL drop_accept: got %b expected 1", fi.req_ready); end
        @(posedge clk); #1;
        fi.req_valid = 1'b0; di.req_valid = 1'b1; di.req_addr = 32'h4;
        @(negedge clk);
        checks++; if (di.req_ready !== 1'b0) begin errors++; $display("FAIL drop_wait: got %b expected 0", di.req_ready); end
        @(posedge clk); #1;
        di.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (fi.rsp_valid !== 1'b1) begin errors++; $display("FAIL drop_owner_rsp: got %b expected 1", fi.rsp_valid); end
        @(posedge clk); #1;
        exp_last = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (di.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_txn[%0d]: got dvalid=%b busy=%b expected 0 0", i, di.rsp_valid, busy); end
        end
        @(posedge clk); #1;
        run_txn(1'b1, 32'h0, 1'b1, 32'h4, o);
        exp = exp_winner(1'b1, 1'b1, exp_last); exp_last = exp;
        fi.req_valid = 1'b0; di.req_valid = 1'b0;
        checks++; if (o.who !== exp) begin errors++; $display("FAIL drop_next_tie: got %0d expected %0d", o.who, exp); end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        do_reset();
        fi.req_valid = 1'b1; fi.req_addr = 32'h8; di.req_valid = 1'b0;
        @(posedge clk); #1;
        fi.req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL abort_in_access: got busy=%b addr=%h expected 1 00000008", busy, mem_addr); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL abort_async: got busy=%b addr=%h expected 0 00000000", busy, mem_addr); end
        checks++; if (fi.rsp_valid !== 1'b0 || fi.rsp_data !== 32'h0 || fi.rsp_err !== 1'b0) begin errors++; $display("FAIL abort_rsp: got %b %h %b expected 0 0 0", fi.rsp_valid, fi.rsp_data, fi.rsp_err); end
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (fi.rsp_valid !== 1'b0 || di.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_rsp[%0d]: got f=%b d=%b busy=%b expected 0 0 0", i, fi.rsp_valid, di.rsp_valid, busy); end
        end
        @(posedge clk); #1;
        exp_last = 1;
        run_txn(1'b1, 32'h0, 1'b1, 32'h4, o);
        fi.req_valid = 1'b0; di.req_valid = 1'b0;
        checks++; if (o.who !== exp_winner(1'b1, 1'b1, exp_last) || o.lat !== 2 || o.data !== 32'h00500113) begin errors++; $display("FAIL abort_next_txn: got who=%0d lat=%0d %h expected 0 2 00500113", o.who, o.lat, o.data); end
        exp_last = 0;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   exp;
        int   prev_acc;
        do_reset();
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b1, 32'h8, 1'b1, 32'h4, o);
            exp = exp_winner(1'b1, 1'b1, exp_last); exp_last = exp;
            checks++; if (o.who !== exp) begin errors++; $display("FAIL b2b_who[%0d]: got %0d expected %0d", i, o.who, exp); end
            checks++; if (o.lat !== 2 || o.data !== (exp == 0 ? 32'hFF718393 : 32'h00C00193)) begin errors++; $display("FAIL b2b_rsp[%0d]: got lat=%0d %h expected 2 %h", i, o.lat, o.data, exp == 0 ? 32'hFF718393 : 32'h00C00193); end
            if (i > 0) begin
                checks++; if (o.acc - prev_acc !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, o.acc - prev_acc); end
            end
            prev_acc = o.acc;
        end
        fi.req_valid = 1'b0; di.req_valid = 1'b0;
    endtask

    task automatic test_random();
        obs_t        o;
        logic        fv;
        logic        dv;
        logic [31:0] fa;
        logic [31:0] da;
        logic [31:0] ea;
        int          exp;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            fv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            if (!fv && !dv) begin
                if ($urandom_range(0, 1) == 1) fv = 1'b1;
                else dv = 1'b1;
            end
            fa = rand_addr();
            da = rand_addr();
            run_txn(fv, fa, dv, da, o);
            exp = exp_winner(fv, dv, exp_last); exp_last = exp;
            ea  = (exp == 1) ? da : fa;
            checks++; if (o.timeout !== 1'b0 || o.who !== exp || o.lat !== 2) begin errors++; $display("FAIL rnd_txn[%0d]: got to=%b who=%0d lat=%0d expected 0 %0d 2", i, o.timeout, o.who, o.lat, exp); end
            checks++; if (o.data !== exp_word(ea) || o.err !== !addr_valid(ea)) begin errors++; $display("FAIL rnd_rsp[%0d] addr %h: got %h/%b expected %h/%b", i, ea, o.data, o.err, exp_word(ea), !addr_valid(ea)); end
            checks++; if (o.maddr !== (addr_valid(ea) ? ea : 32'h0) || o.other !== 1'b0) begin errors++; $display("FAIL rnd_mem[%0d]: got addr=%h other=%b expected %h 0", i, o.maddr, o.other, addr_valid(ea) ? ea : 32'h0); end
            if ($urandom_range(0, 3) == 0) begin
                fi.req_valid = 1'b0; di.req_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        fi.req_valid = 1'b0; di.req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'h00500113;
        mem[1] = 32'h00C00193;
        mem[2] = 32'hFF718393;
        test_reset();
        test_single_fetch();
        test_tie();
        test_addr_errors();
        test_backpressure();
        test_drop();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, default 128, size of instruction memory in bytes.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: f_req_valid / f_req_ready  in / out  1 / 1  fetch request handshake.
REQ-005 Port: f_req_addr  in  32  fetch byte address.
REQ-006 Port: f_rsp_valid / f_rsp_ready  out / in  1 / 1  fetch response handshake.
REQ-007 Port: f_rsp_data / f_rsp_err  out / out  32 / 1  fetch instruction word, error flag.
REQ-008 Port: d_req_valid, d_req_ready, d_req_addr, d_rsp_valid, d_rsp_ready, d_rsp_data, d_rsp_err; debug requester, same directions and widths as the fetch requester.
REQ-009 Port: mem_addr  out  32  byte address to instruction memory (combinational-read, little-endian word).
REQ-010 Port: mem_rdata  in  32  word returned by instruction memory.
REQ-011 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS, RESP, encoded in a registered state variable.
REQ-013 IDLE: only one req_valid high -> that requester granted; both high -> requester not in last_grant wins (round-robin).
REQ-014 req_ready SHALL be high only in IDLE and only for the granted requester, combinationally; all other times 0.
REQ-015 Accept (valid & ready, cycle N): latch addr, owner; update last_grant := owner; state -> ACCESS.
REQ-016 ACCESS (N+1): mem_addr = latched addr; capture mem_rdata into response register; state -> RESP.
REQ-017 mem_addr SHALL be 32'h0 outside ACCESS and for errored accesses.
REQ-018 Address valid iff addr[1:0]==2'b00 and addr <= MEM_BYTES-4 (unsigned 32-bit compare, no wrap).
REQ-019 Invalid address: rsp_data = 32'h0, rsp_err = 1; otherwise rsp_err = 0, rsp_data = mem_rdata.
REQ-020 RESP (N+2 onward): owner's rsp_valid high, data/err stable until rsp_ready sampled high; other requester's rsp_valid 0.
REQ-021 On rsp handshake: state -> IDLE; rsp_valid low next cycle; new request accepted no earlier than following cycle (min 3 cycles per transaction).
REQ-022 rsp_ready while rsp_valid low SHALL be ignored.
REQ-023 Requester dropping req_valid before accept: no transaction; requester state unchanged; last_grant unchanged.
REQ-024 Request arriving during ACCESS/RESP SHALL wait (ready 0); after return to IDLE, arbitrated per REQ-013.
REQ-025 Neither requester starved: under continuous dual requests, grants SHALL alternate F,D,F,D...

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, last_grant = debug, all rsp_valid 0, rsp_data 32'h0, rsp_err 0, busy 0, mem_addr 32'h0.
REQ-027 Reset during ACCESS or RESP SHALL abort the transaction; its response is never presented.
REQ-028 First arbitration after reset with both valid SHALL grant fetch.

Verification
REQ-029 Fetch only, addr 0x0, memory word 32'h00500113, rsp_ready=1 -> accept N, f_rsp_valid N+2, data 32'h00500113, err 0.
REQ-030 Both valid from reset, addrs F=0x8, D=0x4 -> F granted first (32'hFF718393), then D (32'h00C00193); next tie grants F.
REQ-031 Debug addr 0x6 (misaligned) and addr 0x80 with MEM_BYTES=128 -> d_rsp_err 1, data 32'h0, mem_addr stays 0.
REQ-032 f_rsp_ready held low 5 cycles -> f_rsp_valid, data stable 5 cycles, d_req_ready 0 throughout, busy 1.
REQ-033 reset_n pulsed low in ACCESS -> outputs at reset values asynchronously, no response after release, next accept from IDLE.
REQ-034 Continuous dual requests 8 transactions -> grant order F,D,F,D,F,D,F,D, each response 2 cycles after accept.
